// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
//   ALU_W / MODE_W : default operand width and mode-code width
//   ALU_* : mode codes as seen on the ALU modeSelect input
//   alu_cmd_t : command payload {mode, a, b, c}
//   issue_state_e : issue FSM states
package alu_pkg;

    localparam int unsigned ALU_W  = 4;
    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] ALU_NOTA = 3'b000;
    localparam logic [MODE_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [MODE_W-1:0] ALU_AND  = 3'b010;
    localparam logic [MODE_W-1:0] ALU_OR   = 3'b011;
    localparam logic [MODE_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [MODE_W-1:0] ALU_ROT  = 3'b101;
    localparam logic [MODE_W-1:0] ALU_ZERO = 3'b110;
    localparam logic [MODE_W-1:0] ALU_ONES = 3'b111;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [ALU_W-1:0]  a;
        logic [ALU_W-1:0]  b;
        logic              c;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bus bundle of the ALU issue stage: command port, ALU drive/return, response port.
//   slave  : the issue stage's view
//   master : the environment's view (command producer, ALU, response consumer)
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [MODE_W-1:0] cmd_mode;
    logic [WIDTH-1:0]  cmd_a;
    logic [WIDTH-1:0]  cmd_b;
    logic              cmd_c;

    logic [MODE_W-1:0] alu_mode;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic              alu_c;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [MODE_W-1:0] rsp_mode;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_carry;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_c,
        output cmd_ready,
        output alu_mode, alu_a, alu_b, alu_c,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_mode, rsp_result, rsp_carry,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_c,
        input  cmd_ready,
        input  alu_mode, alu_a, alu_b, alu_c,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_mode, rsp_result, rsp_carry,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, pointers wrap naturally.
//   clock, reset : clock, async active-high reset (empties the FIFO)
//   push, wdata  : write request/data (ignored when full)
//   pop, rdata   : read request (ignored when empty) / head entry, combinational
//   full, empty, count : occupancy, all derived from the registered count
module alu_cmd_fifo #(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 12,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array, no reset needed: entries are only read when counted valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a registered ALU: buffers commands, drives one at a time
// onto the ALU inputs, waits out the ALU latency, and returns the captured
// result tagged with its mode on a valid/ready response port.
//   clock, reset : clock, async active-high reset (drops any in-flight command)
//   bus.cmd_*    : command valid/ready port (cmd_ready = FIFO not full)
//   bus.alu_*    : ALU operand drive (mode/a/b/c) and result return (result/carry)
//   bus.rsp_*    : response valid/ready port (mode/result/carry)
//   busy         : an operation is in progress or commands are queued
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    alu_issue_stage_if.slave bus,
    output logic             busy
);

    localparam int unsigned CMD_W = MODE_W + 2 * WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    logic              fifo_push;
    logic              fifo_pop;
    logic [CMD_W-1:0]  fifo_wdata;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic [MODE_W-1:0] hd_mode;
    logic [WIDTH-1:0]  hd_a;
    logic [WIDTH-1:0]  hd_b;
    logic              hd_c;

    issue_state_e      state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              load_head;

    logic [MODE_W-1:0] alu_mode_q, alu_mode_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic              alu_c_q, alu_c_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [MODE_W-1:0] rsp_mode_q, rsp_mode_d;
    logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;

    // Every accepted command goes through the FIFO; cmd_ready sees only the registered count.
    assign bus.cmd_ready = (fifo_count != CNT_W'(DEPTH));
    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign fifo_wdata    = {bus.cmd_mode, bus.cmd_a, bus.cmd_b, bus.cmd_c};

    assign hd_mode = fifo_rdata[CMD_W-1 -: MODE_W];
    assign hd_a    = fifo_rdata[2*WIDTH -: WIDTH];
    assign hd_b    = fifo_rdata[WIDTH -: WIDTH];
    assign hd_c    = fifo_rdata[0];

    alu_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Issue FSM: pop -> wait ALU latency -> hold response until accepted.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_head    = 1'b0;
        fifo_pop     = 1'b0;
        alu_mode_d   = alu_mode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_c_d      = alu_c_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_mode_d   = rsp_mode_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load_head = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_W'(ALU_LAT)) begin
                    rsp_valid_d  = 1'b1;
                    rsp_mode_d   = alu_mode_q;
                    rsp_result_d = bus.alu_result;
                    rsp_carry_d  = bus.alu_carry;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load_head = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Head-of-queue issue; alu_* then hold until the next issue.
        if (load_head) begin
            fifo_pop   = 1'b1;
            alu_mode_d = hd_mode;
            alu_a_d    = hd_a;
            alu_b_d    = hd_b;
            alu_c_d    = hd_c;
            cnt_d      = '0;
            state_d    = WAIT;
        end
    end

    // State, ALU drive and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_mode_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_c_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_mode_q   <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_mode_q   <= alu_mode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_c_q      <= alu_c_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_mode_q   <= rsp_mode_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign bus.alu_mode   = alu_mode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_c      = alu_c_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_mode   = rsp_mode_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule
